// File: rtl/axis_pkt_sink_if.sv
// axis_pkt_sink_if: AXI-Stream beat bundle between a packet source and the packet sink.
interface axis_pkt_sink_if #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2
);
    logic              TVALID;
    logic              TREADY;
    logic [TDATAW-1:0] TDATA;
    logic              TLAST;
    logic [TIDW-1:0]   TID;
    logic [TDESTW-1:0] TDEST;
    modport master (output TVALID, TDATA, TLAST, TID, TDEST, input TREADY);
    modport slave  (input TVALID, TDATA, TLAST, TID, TDEST, output TREADY);
endinterface

// File: rtl/axis_pkt_sink.sv
// axis_pkt_sink: AXI-Stream packet sink reporting length, checksum and error statistics.
module axis_pkt_sink #(
    parameter int                TDATAW      = 32,
    parameter int                TDESTW      = 4,
    parameter int                TIDW        = 2,
    parameter logic [TDESTW-1:0] MY_DEST     = 4'h1,
    parameter int                EXP_LEN     = 1,
    parameter int                CNTW        = 16,
    parameter int                STALL_EVERY = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ENABLE,
    input  logic                 CLEAR,
    axis_pkt_sink_if.slave       axis_s,
    output logic                 PKT_DONE,
    output logic [CNTW-1:0]      PKT_LEN,
    output logic [TDATAW-1:0]    PKT_SUM,
    output logic [CNTW-1:0]      PKT_CNT,
    output logic [CNTW-1:0]      ERR_CNT,
    output logic                 ERR_LEN,
    output logic                 ERR_DEST,
    output logic                 BUSY
);
    localparam int SW = STALL_EVERY > 1 ? $clog2(STALL_EVERY) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_EVERY > 0 ? STALL_EVERY - 1 : 0);
    localparam logic [CNTW-1:0] CMAX = '1;

    typedef enum logic {IDLE, RECV} state_t;
    state_t state;

    logic [SW-1:0]     stall_cnt, stall_nxt;
    logic [CNTW-1:0]   beat_cnt, len_nxt;
    logic [TDATAW-1:0] sum, sum_nxt;
    logic              derr, derr_nxt, acc, stall_slot, len_bad, unused_tid;

    assign unused_tid = ^axis_s.TID;
    assign BUSY = state == RECV;

    // The first beat of a packet (state IDLE) loads the accumulators instead of adding to them.
    always_comb begin
        acc        = axis_s.TVALID & axis_s.TREADY;
        stall_nxt  = (!ENABLE || stall_cnt == STALL_LAST) ? '0 : stall_cnt + SW'(1);
        stall_slot = STALL_EVERY != 0 && stall_nxt == STALL_LAST;
        len_nxt    = state == IDLE ? CNTW'(1) : beat_cnt + CNTW'(beat_cnt != CMAX);
        sum_nxt    = (state == IDLE ? '0 : sum) + axis_s.TDATA;
        derr_nxt   = (state == IDLE ? 1'b0 : derr) | (axis_s.TDEST != MY_DEST);
        len_bad    = len_nxt != CNTW'(EXP_LEN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            stall_cnt     <= '0;
            axis_s.TREADY <= 1'b0;
            beat_cnt      <= '0;
            sum           <= '0;
            derr          <= 1'b0;
            PKT_DONE      <= 1'b0;
            PKT_LEN       <= '0;
            PKT_SUM       <= '0;
            PKT_CNT       <= '0;
            ERR_CNT       <= '0;
            ERR_LEN       <= 1'b0;
            ERR_DEST      <= 1'b0;
        end else begin
            PKT_DONE      <= 1'b0;
            stall_cnt     <= stall_nxt;
            axis_s.TREADY <= ENABLE & ~CLEAR & ~stall_slot;
            if (CLEAR) begin
                state    <= IDLE;
                beat_cnt <= '0;
                sum      <= '0;
                derr     <= 1'b0;
                PKT_LEN  <= '0;
                PKT_SUM  <= '0;
                PKT_CNT  <= '0;
                ERR_CNT  <= '0;
                ERR_LEN  <= 1'b0;
                ERR_DEST <= 1'b0;
            end else if (acc) begin
                beat_cnt <= len_nxt;
                sum      <= sum_nxt;
                derr     <= derr_nxt;
                state    <= axis_s.TLAST ? IDLE : RECV;
                if (axis_s.TLAST) begin
                    PKT_DONE <= 1'b1;
                    PKT_LEN  <= len_nxt;
                    PKT_SUM  <= sum_nxt;
                    PKT_CNT  <= PKT_CNT + CNTW'(PKT_CNT != CMAX);
                    if (len_bad || derr_nxt) ERR_CNT <= ERR_CNT + CNTW'(ERR_CNT != CMAX);
                    ERR_LEN  <= ERR_LEN | len_bad;
                    ERR_DEST <= ERR_DEST | derr_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_pkt_sink.sv
// tb_axis_pkt_sink: table-driven packets checked through a completion scoreboard,
// plus hand sequences for enable, clear, backpressure and async reset.
module tb_axis_pkt_sink;
    logic CLK = 1'b0;
    logic RST_N, ENABLE, CLEAR;
    logic en1 = 1'b1, clr1 = 1'b0;
    logic pkt_done, err_len, err_dest, busy;
    logic [15:0] pkt_len, pkt_cnt, err_cnt;
    logic [31:0] pkt_sum;
    logic d1_done, d1_elen, d1_edest, d1_busy;
    logic [15:0] d1_len, d1_cnt, d1_ecnt;
    logic [31:0] d1_sum;
    int n_chk = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    axis_pkt_sink_if #(.TDATAW(32), .TDESTW(4), .TIDW(2)) s0 ();
    axis_pkt_sink_if #(.TDATAW(32), .TDESTW(4), .TIDW(2)) s1 ();

    axis_pkt_sink dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .CLEAR(CLEAR), .axis_s(s0),
        .PKT_DONE(pkt_done), .PKT_LEN(pkt_len), .PKT_SUM(pkt_sum), .PKT_CNT(pkt_cnt),
        .ERR_CNT(err_cnt), .ERR_LEN(err_len), .ERR_DEST(err_dest), .BUSY(busy)
    );

    axis_pkt_sink #(.STALL_EVERY(4)) dut_bp (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(en1), .CLEAR(clr1), .axis_s(s1),
        .PKT_DONE(d1_done), .PKT_LEN(d1_len), .PKT_SUM(d1_sum), .PKT_CNT(d1_cnt),
        .ERR_CNT(d1_ecnt), .ERR_LEN(d1_elen), .ERR_DEST(d1_edest), .BUSY(d1_busy)
    );

    typedef struct {
        int              n;
        logic [2:0][31:0] d;
        logic [3:0]      dst;
        logic            gap;
        logic [31:0]     sum;
        logic            le, de;
    } vec_t;

    typedef struct {
        logic [15:0] len;
        logic [31:0] sum;
        logic [15:0] cnt, ecnt;
        logic        elen, edest;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];
    logic [15:0] m_cnt, m_ecnt;
    logic m_elen, m_edest;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(int n, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                logic [3:0] dst, logic gap, logic [31:0] sum, logic le, logic de);
        vec_t v;
        v.n = n; v.d[0] = a; v.d[1] = b; v.d[2] = c;
        v.dst = dst; v.gap = gap; v.sum = sum; v.le = le; v.de = de;
        return v;
    endfunction

    function automatic void model_clear();
        m_cnt = 0; m_ecnt = 0; m_elen = 0; m_edest = 0;
    endfunction

    function automatic void expect_pkt(logic [15:0] len, logic [31:0] sum, logic le, logic de);
        exp_t e;
        m_cnt++;
        if (le || de) m_ecnt++;
        m_elen = m_elen | le;
        m_edest = m_edest | de;
        e.len = len; e.sum = sum; e.cnt = m_cnt; e.ecnt = m_ecnt; e.elen = m_elen; e.edest = m_edest;
        sb.push_back(e);
    endfunction

    task automatic beat(input logic [31:0] d, input logic [3:0] dst, input logic last);
        logic acc;
        s0.TVALID = 1'b1; s0.TDATA = d; s0.TDEST = dst; s0.TLAST = last;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            acc = s0.TREADY;
            @(posedge CLK);
            #1;
            if (acc) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL beat_timeout: data %h never accepted within 100 cycles", d);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (pkt_done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got PKT_DONE=1 expected 0 (len %h sum %h)", pkt_len, pkt_sum);
                end else begin
                    e = sb.pop_front();
                    chk("pkt_len", pkt_len, e.len);
                    chk("pkt_sum", pkt_sum, e.sum);
                    chk("pkt_cnt", pkt_cnt, e.cnt);
                    chk("err_cnt", err_cnt, e.ecnt);
                    chk("err_len", err_len, e.elen);
                    chk("err_dest", err_dest, e.edest);
                end
            end
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_tready"}, s0.TREADY, 0);
        chk({tag, "_done"}, pkt_done, 0);
        chk({tag, "_len"}, pkt_len, 0);
        chk({tag, "_sum"}, pkt_sum, 0);
        chk({tag, "_cnt"}, pkt_cnt, 0);
        chk({tag, "_ecnt"}, err_cnt, 0);
        chk({tag, "_elen"}, err_len, 0);
        chk({tag, "_edest"}, err_dest, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int acc_n, low_n;
        RST_N = 1'b0; ENABLE = 1'b0; CLEAR = 1'b0;
        s0.TVALID = 0; s0.TDATA = 0; s0.TLAST = 0; s0.TID = 0; s0.TDEST = 0;
        s1.TVALID = 0; s1.TDATA = 0; s1.TLAST = 0; s1.TID = 0; s1.TDEST = 4'h1;
        model_clear();
        tbl[0] = mk(1, 32'h5A, 0, 0, 4'h1, 0, 32'h5A, 0, 0);
        tbl[1] = mk(3, 32'hFFFF_FFFF, 32'h2, 32'h3, 4'h1, 0, 32'h4, 1, 0);
        tbl[2] = mk(1, 32'h10, 0, 0, 4'h2, 0, 32'h10, 0, 1);
        tbl[3] = mk(1, 32'h20, 0, 0, 4'h1, 0, 32'h20, 0, 0);
        tbl[4] = mk(2, 32'h1, 32'h2, 0, 4'h1, 1, 32'h3, 1, 0);
        tbl[5] = mk(1, 32'hDEAD_BEEF, 0, 0, 4'h1, 0, 32'hDEAD_BEEF, 0, 0);
        tbl[6] = mk(3, 32'h10, 32'h20, 32'h30, 4'h1, 1, 32'h60, 1, 0);
        fork monitor(); join_none
        #1 chk_zero("rst");
        ENABLE = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        chk("tready_pre_edge", s0.TREADY, 0);
        @(posedge CLK); #1;
        chk("tready_after_rst", s0.TREADY, 1);

        // packets run back to back; gap entries drop TVALID after the first beat
        for (int p = 0; p < 7; p++) begin
            for (int b = 0; b < tbl[p].n; b++) begin
                beat(tbl[p].d[b], b == 0 ? tbl[p].dst : 4'h1, b == tbl[p].n - 1);
                if (tbl[p].gap && b == 0 && tbl[p].n > 1) begin
                    s0.TVALID = 1'b0;
                    @(posedge CLK); #1;
                    chk("busy_hold", busy, 1);
                end
            end
            expect_pkt(16'(tbl[p].n), tbl[p].sum, tbl[p].le, tbl[p].de);
        end
        s0.TVALID = 1'b0;
        repeat (2) @(posedge CLK); #1;

        ENABLE = 1'b0;
        @(posedge CLK); #1;
        chk("tready_en_fall", s0.TREADY, 0);
        ENABLE = 1'b1;
        @(negedge CLK);
        chk("tready_en_wait", s0.TREADY, 0);
        @(posedge CLK); #1;
        chk("tready_en_rise", s0.TREADY, 1);

        beat(32'h1, 4'h1, 0);
        beat(32'h2, 4'h1, 0);
        chk("busy_mid", busy, 1);
        CLEAR = 1'b1; s0.TDATA = 32'h99; s0.TLAST = 1'b1;
        @(posedge CLK); #1;
        CLEAR = 1'b0; s0.TVALID = 1'b0;
        chk("clr_tready", s0.TREADY, 0);
        chk("clr_busy", busy, 0);
        chk("clr_cnt", pkt_cnt, 0);
        chk("clr_ecnt", err_cnt, 0);
        chk("clr_flags", {err_len, err_dest}, 0);
        chk("clr_len", pkt_len, 0);
        chk("clr_sum", pkt_sum, 0);
        model_clear();
        beat(32'h7, 4'h1, 1);
        s0.TVALID = 1'b0;
        expect_pkt(16'd1, 32'h7, 0, 0);
        repeat (2) @(posedge CLK); #1;

        acc_n = 0; low_n = 0;
        s1.TVALID = 1'b1; s1.TLAST = 1'b1;
        for (int c = 0; c < 40; c++) begin
            s1.TDATA = 32'(c);
            @(negedge CLK);
            if (s1.TREADY) acc_n++; else low_n++;
            @(posedge CLK); #1;
        end
        s1.TVALID = 1'b0;
        chk("bp_accepted", 32'(acc_n), 30);
        chk("bp_stalls", 32'(low_n), 10);
        chk("bp_pkt_cnt", d1_cnt, 16'(acc_n));

        beat(32'h1, 4'h1, 0);
        beat(32'h2, 4'h1, 0);
        s0.TVALID = 1'b0;
        chk("busy_pre_rst", busy, 1);
        #2 RST_N = 1'b0;
        #1 chk_zero("arst");
        model_clear();
        @(negedge CLK) RST_N = 1'b1;
        chk("arst_tready_wait", s0.TREADY, 0);
        @(posedge CLK); #1;
        chk("arst_tready_rise", s0.TREADY, 1);
        beat(32'h11, 4'h1, 1);
        s0.TVALID = 1'b0;
        expect_pkt(16'd1, 32'h11, 0, 0);

        repeat (3) @(posedge CLK); #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
